cpu_mem_arbiter: RTL and testbench
==================================

Name: cpu_mem_arbiter

Overview:
- Shares one synchronous single-port 64 KiB RAM between the cpu_6502 core and a DMA/loader requester.
- Decides once per cycle who owns the RAM port. Stalls the CPU through RDY whenever the DMA side owns the port.
- Holds the CPU's DI stable across stalls.
- Sits between cpu_6502 and the RAM in both the SoC top and the functional benches. It replaces the bench's direct rdy-gated RAM hookup.

Parameters:
- AW, 16, address width.
- DW, 8, data width.
- MAX_DMA_BURST, 4, maximum consecutive DMA grants before one CPU slot is forced (range 1..255).

Ports:
- clk  in  1  system clock. One clock domain only.
- rst_n  in  1  reset, asynchronous and active-low.
- cpu_ab  in  AW  CPU address (AB).
- cpu_do  in  DW  CPU write data (DO).
- cpu_we  in  1  CPU write enable (WE).
- cpu_rdy  out  1  to CPU RDY. 1 means the CPU access is performed this cycle.
- cpu_di  out  DW  to CPU DI.
- ext_rdy  in  1  external wait request. 0 stalls the CPU regardless of DMA.
- dma_req  in  1  DMA request. Held with its address and data until granted.
- dma_we  in  1  DMA write.
- dma_addr  in  AW  DMA address.
- dma_wdata  in  DW  DMA write data.
- dma_gnt  out  1  combinational. Access accepted this cycle.
- dma_rvalid  out  1  DMA read data valid.
- dma_rdata  out  DW  DMA read data.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid the cycle after a read with mem_en=1.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=S_CPU, burst_cnt=0, owner_q=NONE, cpu_di_hold=0.
  - Outputs while in reset: cpu_rdy=0, dma_gnt=0, dma_rvalid=0, mem_en=0, cpu_di=0.
  - Asserting reset mid-access discards that access. No rvalid follows it.
- Per-cycle grant (combinational from registered state and inputs):
  - dma_win = dma_req && burst_cnt < MAX_DMA_BURST.
  - If dma_win: dma_gnt=1, cpu_rdy=0, mem_* driven from dma_*, mem_en=1.
  - Else if ext_rdy: cpu_rdy=1, mem_* driven from cpu_*, mem_en=1.
  - Else: cpu_rdy=0, dma_gnt=0, mem_en=0 (idle slot).
- FSM: S_CPU and S_DMA.
  - In S_CPU, a dma_win moves to S_DMA with burst_cnt=1.
  - In S_DMA, each further dma_win increments burst_cnt.
  - In S_DMA, a cycle without dma_win returns to S_CPU.
  - Whenever the CPU is actually granted (cpu_rdy=1), burst_cnt clears to 0.
  - Idle slots (ext_rdy=0 with no dma_win) do not clear burst_cnt.
  - Consequence: with dma_req held high, the pattern is MAX_DMA_BURST DMA slots, then exactly one CPU slot. If ext_rdy is low, DMA is locked out until that CPU slot happens.
  - When dma_req is high and burst_cnt has reached MAX_DMA_BURST, dma_gnt=0. A slot with ext_rdy=1 serves the CPU; a slot with ext_rdy=0 is idle.
- Read return:
  - owner_q registers {NONE, CPU_RD, DMA_RD, WR} for the access issued last cycle.
  - cpu_di = mem_rdata if owner_q==CPU_RD, else cpu_di_hold. cpu_di_hold loads mem_rdata whenever owner_q==CPU_RD.
  - Result: DI stays stable through any number of stall cycles, including across intervening DMA reads.
  - dma_rvalid = (owner_q==DMA_RD). dma_rdata = mem_rdata.
  - CPU and DMA writes produce no rvalid.
- Write ordering:
  - Accesses complete in grant order.
  - A DMA write followed by a CPU read of the same address in the next slot returns the new data (the RAM is write-first/ordered).
- Latency: grant is in the same cycle as the request; read data arrives 1 cycle after grant.
- Width rules: no address or data transformation. MAX_DMA_BURST is compared with an 8-bit burst_cnt, which saturates and never wraps.

Test Plan:
- Reset release, no DMA, ext_rdy=1, RAM loaded with the 6502 functional test image, reset vector 0x0400: cpu_rdy=1 every cycle, cpu_inst.PC reaches 0x3469, cycle count identical to the unarbitrated bench.
- dma_req held, MAX_DMA_BURST=4: grant pattern is DDDDC repeating; cpu_rdy high exactly 1 of every 5 cycles; no DMA starvation and no CPU starvation.
- CPU reads 0x1234=0xA5, then a DMA read of 0x0010=0x3C intervenes for 3 stall cycles: cpu_di stays 0xA5 throughout; dma_rvalid pulses once with 0x3C.
- DMA writes 0x77 to 0x0200, then CPU reads 0x0200 in the next slot: cpu_di=0x77 one cycle later.
- ext_rdy=0 for 10 cycles with dma_req high from cycle 0 and MAX_DMA_BURST=4: 4 grants, then idle slots with dma_gnt=0 until ext_rdy=1; first CPU slot then clears burst_cnt.
- rst_n asserted asynchronously mid DMA read: mem_en, dma_gnt, dma_rvalid and cpu_rdy drop immediately; no rvalid after release; CPU restarts from the reset vector.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// Shares one synchronous single-port RAM between the 6502 core and a DMA/loader port.
// DMA wins each slot until its burst budget is spent; the CPU is stalled through RDY otherwise.
module cpu_mem_arbiter #(
    parameter int unsigned AW            = 16,
    parameter int unsigned DW            = 8,
    parameter int unsigned MAX_DMA_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] cpu_ab,
    input  logic [DW-1:0] cpu_do,
    input  logic          cpu_we,
    output logic          cpu_rdy,
    output logic [DW-1:0] cpu_di,
    input  logic          ext_rdy,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_DMA_BURST);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    typedef enum logic {S_CPU, S_DMA} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU_RD, OWN_DMA_RD, OWN_WR} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [DW-1:0]     cpu_di_hold_q, cpu_di_hold_d;
    logic              dma_win;
    logic              cpu_go;

    // Slot decision; gated by rst_n so grants drop the instant reset asserts.
    always_comb begin
        dma_win = rst_n && dma_req && (burst_cnt_q < CNT_MAX);
        cpu_go  = rst_n && !dma_win && ext_rdy;
    end

    always_comb begin
        dma_gnt   = dma_win;
        cpu_rdy   = cpu_go;
        mem_en    = dma_win || cpu_go;
        mem_we    = dma_win ? dma_we    : (cpu_go && cpu_we);
        mem_addr  = dma_win ? dma_addr  : cpu_ab;
        mem_wdata = dma_win ? dma_wdata : cpu_do;
    end

    // Read return: CPU DI is held across stalls and intervening DMA reads.
    always_comb begin
        cpu_di        = (owner_q == OWN_CPU_RD) ? mem_rdata : cpu_di_hold_q;
        cpu_di_hold_d = (owner_q == OWN_CPU_RD) ? mem_rdata : cpu_di_hold_q;
        dma_rvalid    = (owner_q == OWN_DMA_RD);
        dma_rdata     = mem_rdata;
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        owner_d     = OWN_NONE;
        if (dma_win) begin
            owner_d = dma_we ? OWN_WR : OWN_DMA_RD;
            state_d = S_DMA;
            if (state_q == S_CPU) begin
                burst_cnt_d = CNT_W'(1);
            end else if (burst_cnt_q != CNT_SAT) begin
                burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
        end else if (cpu_go) begin
            owner_d     = cpu_we ? OWN_WR : OWN_CPU_RD;
            state_d     = S_CPU;
            burst_cnt_d = '0;
        end else begin
            // Idle slot keeps the burst count so a stalled CPU still gets its turn.
            state_d = S_CPU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_CPU;
            owner_q       <= OWN_NONE;
            burst_cnt_q   <= '0;
            cpu_di_hold_q <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            burst_cnt_q   <= burst_cnt_d;
            cpu_di_hold_q <= cpu_di_hold_d;
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter with a write-first synchronous RAM model.
module tb_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic        cpu_rdy;
    logic [7:0]  cpu_di;
    logic        ext_rdy;
    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [7:0]  dma_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  ram [0:65535];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_cpu    = 0;

    cpu_mem_arbiter #(.AW(16), .DW(8), .MAX_DMA_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
        .cpu_rdy(cpu_rdy), .cpu_di(cpu_di), .ext_rdy(ext_rdy),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .dma_rdata(dma_rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic er, input logic cwe, input logic [15:0] cab,
                         input logic dreq, input logic dwe, input logic [15:0] dad,
                         input logic [7:0] dwd);
        ext_rdy = er; cpu_we = cwe; cpu_ab = cab; cpu_do = 8'h00;
        dma_req = dreq; dma_we = dwe; dma_addr = dad; dma_wdata = dwd;
        #1;
    endtask

    initial begin
        ram[16'h1234] = 8'hA5;
        ram[16'h0010] = 8'h3C;
        ram[16'h0200] = 8'h00;
        mem_rdata = 8'h00;
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h0010, 8'h00);
        #12;
        chk("rst_cpu_rdy", 16'(cpu_rdy), 16'h0);
        chk("rst_dma_gnt", 16'(dma_gnt), 16'h0);
        chk("rst_mem_en", 16'(mem_en), 16'h0);
        chk("rst_rvalid", 16'(dma_rvalid), 16'h0);
        chk("rst_cpu_di", 16'(cpu_di), 16'h0);

        // CPU read 0x1234, then a DMA read and two stalls: DI must hold 0xA5.
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 16'h0010, 8'h00);
        chk("cpu_rd_rdy", 16'(cpu_rdy), 16'h1);
        chk("cpu_rd_addr", mem_addr, 16'h1234);
        chk("cpu_rd_gnt", 16'(dma_gnt), 16'h0);
        tick();
        chk("cpu_rd_di", 16'(cpu_di), 16'h00A5);
        drive(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h0010, 8'h00);
        chk("dma_rd_gnt", 16'(dma_gnt), 16'h1);
        chk("dma_rd_rdy", 16'(cpu_rdy), 16'h0);
        chk("dma_rd_addr", mem_addr, 16'h0010);
        tick();
        chk("stall1_di", 16'(cpu_di), 16'h00A5);
        chk("dma_rvalid", 16'(dma_rvalid), 16'h1);
        chk("dma_rdata", 16'(dma_rdata), 16'h003C);
        drive(1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 16'h0010, 8'h00);
        chk("idle_mem_en", 16'(mem_en), 16'h0);
        chk("idle_rdy", 16'(cpu_rdy), 16'h0);
        tick();
        chk("stall2_di", 16'(cpu_di), 16'h00A5);
        chk("rvalid_once", 16'(dma_rvalid), 16'h0);
        tick();
        chk("stall3_di", 16'(cpu_di), 16'h00A5);

        // DMA write then CPU read of the same address in the next slot.
        drive(1'b1, 1'b0, 16'h0200, 1'b1, 1'b1, 16'h0200, 8'h77);
        chk("dma_wr_gnt", 16'(dma_gnt), 16'h1);
        chk("dma_wr_we", 16'(mem_we), 16'h1);
        chk("dma_wr_data", 16'(mem_wdata), 16'h0077);
        tick();
        chk("wr_no_rvalid", 16'(dma_rvalid), 16'h0);
        drive(1'b1, 1'b0, 16'h0200, 1'b0, 1'b0, 16'h0010, 8'h00);
        chk("raw_rdy", 16'(cpu_rdy), 16'h1);
        chk("raw_we", 16'(mem_we), 16'h0);
        tick();
        chk("raw_di", 16'(cpu_di), 16'h0077);

        // Held dma_req: DDDDC repeating.
        drive(1'b1, 1'b0, 16'h0200, 1'b1, 1'b0, 16'h0010, 8'h00);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("burst_gnt_%0d", i), 16'(dma_gnt), 16'((i % 5) != 4));
            chk($sformatf("burst_rdy_%0d", i), 16'(cpu_rdy), 16'((i % 5) == 4));
            if (cpu_rdy) n_cpu++;
            tick();
        end
        chk("burst_cpu_slots", 16'(n_cpu), 16'd2);

        // ext_rdy low: four grants, then idle slots until the CPU gets its slot.
        drive(1'b0, 1'b0, 16'h0200, 1'b1, 1'b0, 16'h0010, 8'h00);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("lock_gnt_%0d", i), 16'(dma_gnt), 16'(i < 4));
            chk($sformatf("lock_en_%0d", i), 16'(mem_en), 16'(i < 4));
            tick();
        end
        drive(1'b1, 1'b0, 16'h0200, 1'b1, 1'b0, 16'h0010, 8'h00);
        chk("unlock_rdy", 16'(cpu_rdy), 16'h1);
        chk("unlock_gnt", 16'(dma_gnt), 16'h0);
        tick();
        chk("cnt_cleared_gnt", 16'(dma_gnt), 16'h1);
        tick();
        chk("pre_rst_rvalid", 16'(dma_rvalid), 16'h1);
        chk("pre_rst_gnt", 16'(dma_gnt), 16'h1);

        // Asynchronous reset in the middle of a DMA read.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_en", 16'(mem_en), 16'h0);
        chk("arst_gnt", 16'(dma_gnt), 16'h0);
        chk("arst_rvalid", 16'(dma_rvalid), 16'h0);
        chk("arst_rdy", 16'(cpu_rdy), 16'h0);
        chk("arst_di", 16'(cpu_di), 16'h0);
        tick();
        drive(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 16'h0010, 8'h00);
        #2;
        rst_n = 1'b1;
        #1;
        chk("rel_rdy", 16'(cpu_rdy), 16'h1);
        chk("rel_rvalid", 16'(dma_rvalid), 16'h0);
        tick();
        chk("rel_rvalid2", 16'(dma_rvalid), 16'h0);
        chk("rel_cpu_di", 16'(cpu_di), 16'h00A5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
